// File: rtl/store_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : store_drain                                                        |
// | Drains retired stores from the store buffer head to the data cache, one    |
// | sram-like write in flight at a time, in program order.                     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module store_drain #(
  parameter int STORE_GROUP = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [1:0]  retire_store_cnt,
  output logic        commit_store_valid,
  input  logic [3:0]  commit_store_wstrb,
  input  logic [2:0]  commit_store_size,
  input  logic [31:0] commit_store_addr,
  input  logic [31:0] commit_store_data,
  output logic        data_req,
  output logic        data_wr,
  output logic [2:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        store_pending
);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] C_MAX_PENDING = CNT_W'(STORE_GROUP);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_pending_cnt;
  logic [CNT_W-1:0] w_pending_cnt_next;
  logic             w_pop;
  logic             w_slot_free;

  logic [2:0]       r_size;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;

  // A new store may be launched from IDLE or in the very cycle the previous
  // write completes, which gives back-to-back drains with no idle bubble.
  assign w_slot_free = (r_state == C_ST_IDLE) ||
                       ((r_state == C_ST_RESP) && data_data_ok);
  assign w_pop       = w_slot_free && (r_pending_cnt != '0) && !flush && !reset;

  // Retire and pop in the same cycle net out; flush drops any retires this cycle.
  always_comb begin
    w_pending_cnt_next = r_pending_cnt + CNT_W'(retire_store_cnt) - CNT_W'(w_pop);
    if (flush) begin
      w_pending_cnt_next = '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (w_pop) begin
          w_state_next = C_ST_REQ;
        end
      end
      C_ST_REQ: begin
        if (data_addr_ok) begin
          w_state_next = C_ST_RESP;
        end
      end
      C_ST_RESP: begin
        if (data_data_ok) begin
          w_state_next = w_pop ? C_ST_REQ : C_ST_IDLE;
        end
      end
      default: begin
        w_state_next = C_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= C_ST_IDLE;
      r_pending_cnt <= '0;
      r_size        <= '0;
      r_addr        <= '0;
      r_wstrb       <= '0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pending_cnt <= w_pending_cnt_next;
      // Head entry is only valid while the pop pulse is high.
      if (w_pop) begin
        r_size  <= commit_store_size;
        r_addr  <= commit_store_addr;
        r_wstrb <= commit_store_wstrb;
        r_wdata <= commit_store_data;
      end
    end
  end

  assign commit_store_valid = w_pop;
  assign data_req           = (r_state == C_ST_REQ);
  assign data_wr            = (r_state == C_ST_REQ);
  assign data_size          = r_size;
  assign data_addr          = r_addr;
  assign data_wstrb         = r_wstrb;
  assign data_wdata         = r_wdata;
  assign store_pending      = (r_pending_cnt != '0) || (r_state != C_ST_IDLE);

  a_pending_bound: assert property (@(posedge clk) disable iff (reset)
    r_pending_cnt <= C_MAX_PENDING);

  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
    !(w_pop && (r_pending_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_store_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_store_drain                                                     |
// | Cycle-vector table plus store-buffer/cache scoreboard for store_drain.     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_store_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  retire_store_cnt;
  logic        commit_store_valid;
  logic [3:0]  commit_store_wstrb;
  logic [2:0]  commit_store_size;
  logic [31:0] commit_store_addr;
  logic [31:0] commit_store_data;
  logic        data_req;
  logic        data_wr;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        store_pending;

  store_drain #(.STORE_GROUP(16), .CNT_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .retire_store_cnt   (retire_store_cnt),
    .commit_store_valid (commit_store_valid),
    .commit_store_wstrb (commit_store_wstrb),
    .commit_store_size  (commit_store_size),
    .commit_store_addr  (commit_store_addr),
    .commit_store_data  (commit_store_data),
    .data_req           (data_req),
    .data_wr            (data_wr),
    .data_size          (data_size),
    .data_addr          (data_addr),
    .data_wstrb         (data_wstrb),
    .data_wdata         (data_wdata),
    .data_addr_ok       (data_addr_ok),
    .data_data_ok       (data_data_ok),
    .store_pending      (store_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic [2:0]  size;
  } entry_t;

  typedef struct {
    logic [1:0] ret;
    logic       fl;
    logic       rs;
    logic       aok;
    logic       dok;
    logic       exp_pop;
    logic       exp_req;
    logic       exp_pend;
  } vec_t;

  entry_t sb[$];     // store buffer contents: retired, not yet popped
  entry_t exp_q[$];  // popped entries awaiting their cache write
  vec_t   vecs[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_ent   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic entry_t new_entry();
    entry_t e;
    if (n_ent == 0) begin
      e.addr  = 32'h8000_0010;
      e.data  = 32'hDEAD_BEEF;
      e.wstrb = 4'hF;
      e.size  = 3'd2;
    end else begin
      e.addr  = $urandom;
      e.data  = $urandom;
      e.wstrb = 4'($urandom_range(1, 15));
      e.size  = 3'($urandom_range(0, 2));
    end
    n_ent++;
    return e;
  endfunction

  // One clock: drive at posedge+1, sample at negedge, update the scoreboard.
  task automatic step(input logic [1:0] ret, input logic fl, input logic rs,
                      input logic aok, input logic dok,
                      output logic pop, output logic req, output logic pend);
    entry_t e;
    @(posedge clk);
    #1;
    retire_store_cnt = ret;
    flush            = fl;
    reset            = rs;
    data_addr_ok     = aok;
    data_data_ok     = dok;
    for (int k = 0; k < int'(ret); k++) sb.push_back(new_entry());
    if (sb.size() > 0) begin
      commit_store_addr  = sb[0].addr;
      commit_store_data  = sb[0].data;
      commit_store_wstrb = sb[0].wstrb;
      commit_store_size  = sb[0].size;
    end else begin
      commit_store_addr  = '0;
      commit_store_data  = '0;
      commit_store_wstrb = '0;
      commit_store_size  = '0;
    end
    @(negedge clk);
    pop  = commit_store_valid;
    req  = data_req;
    pend = store_pending;
    chk("data_wr", 32'(data_wr), 32'(data_req));
    if (req) begin
      chk("req_has_store", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("data_addr", data_addr, e.addr);
        chk("data_wdata", data_wdata, e.data);
        chk("data_wstrb", 32'(data_wstrb), 32'(e.wstrb));
        chk("data_size", 32'(data_size), 32'(e.size));
        if (aok) void'(exp_q.pop_front());
      end
    end
    if (pop) begin
      chk("pop_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) exp_q.push_back(sb.pop_front());
    end
    if (fl) sb.delete();
    if (rs) begin
      sb.delete();
      exp_q.delete();
    end
  endtask

  function automatic void add(logic [1:0] r, logic f, logic rs, logic a, logic d,
                              logic ep, logic eq, logic en);
    vec_t v;
    v.ret = r; v.fl = f; v.rs = rs; v.aok = a; v.dok = d;
    v.exp_pop = ep; v.exp_req = eq; v.exp_pend = en;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pop, req, pend;
    reset = 1'b1; flush = 1'b0; retire_store_cnt = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    commit_store_addr = '0; commit_store_data = '0;
    commit_store_wstrb = '0; commit_store_size = '0;

    // Columns: ret flush reset aok dok | pop req pend
    // Single store with a slow cache
    add(1,0,0,0,0, 0,0,0); add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 0,1,1);
    add(0,0,0,0,0, 0,1,1); add(0,0,0,1,0, 0,1,1); add(0,0,0,0,0, 0,0,1);
    add(0,0,0,0,1, 0,0,1); add(0,0,0,0,0, 0,0,0);
    // Two stores, second pop coincides with first data_ok
    add(2,0,0,0,0, 0,0,0); add(0,0,0,0,0, 1,0,1); add(0,0,0,1,0, 0,1,1);
    add(0,0,0,0,1, 1,0,1); add(0,0,0,1,0, 0,1,1); add(0,0,0,0,1, 0,0,1);
    add(0,0,0,0,0, 0,0,0);
    // Retire 2 while popping with one pending: two more drains follow
    add(1,0,0,0,0, 0,0,0); add(2,0,0,0,0, 1,0,1); add(0,0,0,1,0, 0,1,1);
    add(0,0,0,0,1, 1,0,1); add(0,0,0,1,0, 0,1,1); add(0,0,0,0,1, 1,0,1);
    add(0,0,0,1,0, 0,1,1); add(0,0,0,0,1, 0,0,1); add(0,0,0,0,0, 0,0,0);
    // Flush after first pop; retire in the flush cycle is dropped
    add(2,0,0,0,0, 0,0,0); add(1,0,0,0,0, 1,0,1); add(1,1,0,0,0, 0,1,1);
    add(0,0,0,1,0, 0,1,1); add(0,0,0,0,0, 0,0,1); add(0,0,0,0,1, 0,0,1);
    add(0,0,0,0,0, 0,0,0);
    // Flush in IDLE suppresses the pop
    add(1,0,0,0,0, 0,0,0); add(0,1,0,0,0, 0,0,1); add(0,0,0,0,0, 0,0,0);
    // Handshakes outside their sampling state are ignored
    add(1,0,0,1,0, 0,0,0); add(0,0,0,0,0, 1,0,1); add(0,0,0,0,1, 0,1,1);
    add(0,0,0,1,0, 0,1,1); add(0,0,0,1,0, 0,0,1); add(0,0,0,0,1, 0,0,1);
    add(0,0,0,0,0, 0,0,0);
    // Reset blocks a pop, then reset abandons a request
    add(1,0,0,0,0, 0,0,0); add(0,0,1,0,0, 0,0,1); add(0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(0,0,0,0,0, 1,0,1); add(0,0,1,0,0, 0,1,1);
    add(0,0,0,0,0, 0,0,0);

    step(0,0,1,0,0, pop, req, pend);
    step(0,0,1,0,0, pop, req, pend);
    chk("rst_pop", 32'(pop), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_strb_size", {25'd0, data_wstrb, data_size}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ret, vecs[i].fl, vecs[i].rs, vecs[i].aok, vecs[i].dok, pop, req, pend);
      chk($sformatf("vec%0d_pop", i), 32'(pop), 32'(vecs[i].exp_pop));
      chk($sformatf("vec%0d_req", i), 32'(req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_pend", i), 32'(pend), 32'(vecs[i].exp_pend));
    end
    chk("post_rst_addr", data_addr, 0);
    chk("post_rst_wdata", data_wdata, 0);

    // Long addr_ok stall with a retire arriving mid-stall
    step(1,0,0,0,0, pop, req, pend);
    chk("stall_pop0", 32'(pop), 0);
    step(0,0,0,0,0, pop, req, pend);
    chk("stall_pop1", 32'(pop), 1);
    for (int i = 0; i < 10; i++) begin
      step((i == 4) ? 2'd1 : 2'd0, 0, 0, 0, 0, pop, req, pend);
      chk($sformatf("stall%0d_req", i), 32'(req), 1);
      chk($sformatf("stall%0d_pop", i), 32'(pop), 0);
    end
    step(0,0,0,1,0, pop, req, pend);
    chk("stall_accept", 32'(req), 1);
    step(0,0,0,0,0, pop, req, pend);
    chk("stall_resp", {30'd0, req, pend}, 32'b01);
    step(0,0,0,0,1, pop, req, pend);
    chk("stall_next_pop", 32'(pop), 1);
    step(0,0,0,1,0, pop, req, pend);
    chk("stall_req2", 32'(req), 1);
    step(0,0,0,0,1, pop, req, pend);
    chk("stall_no_pop", 32'(pop), 0);
    step(0,0,0,0,0, pop, req, pend);
    chk("stall_idle", {30'd0, req, pend}, 0);

    chk("sb_drained", 32'(sb.size()), 0);
    chk("writes_done", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
